// File: rtl/frog_controller.sv
// frog_controller: button synchronise/debounce, frog grid movement, car collision and the
// death/respawn/level/lives state machine. Define FROG_LIVES_EN to enable lives and game over.

module frog_controller #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRID_COLS       = 20,
  parameter int GRID_ROWS       = 15,
  parameter int START_COL       = 10,
  parameter int START_ROW       = 14,
  parameter int DEATH_FRAMES    = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        frame_tick,
  input  logic [54:0] cars_x,
  input  logic [43:0] cars_y,
  output logic [4:0]  frog_col,
  output logic [3:0]  frog_row,
  output logic [3:0]  level,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic        hit,
  output logic        win
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int FR_W  = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [FR_W-1:0]  FR_MAX  = FR_W'(DEATH_FRAMES - 1);
  localparam logic [4:0]       COL_MAX = 5'(GRID_COLS - 1);
  localparam logic [3:0]       ROW_MAX = 4'(GRID_ROWS - 1);
  localparam logic [4:0]       START_C = 5'(START_COL);
  localparam logic [3:0]       START_R = 4'(START_ROW);

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_DEAD = 2'd1,
    S_OVER = 2'd2
  } state_t;

  // Button bit order: 0 up, 1 down, 2 left, 3 right.
  logic [3:0]       btn_raw;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       stable_q, stable_d;
  logic [3:0]       stable_prev_q, stable_prev_d;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];
  logic [3:0]       press;
  logic             mv_up, mv_down, mv_left, mv_right;

  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  always_comb begin
    sync1_d       = btn_raw;
    sync2_d       = sync1_q;
    stable_prev_d = stable_q;
    stable_d      = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          stable_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  // One move per debounced rising edge; a higher-priority press masks the rest.
  assign press    = stable_q & ~stable_prev_q;
  assign mv_up    = press[0];
  assign mv_down  = press[1] & ~press[0];
  assign mv_left  = press[2] & ~press[1] & ~press[0];
  assign mv_right = press[3] & ~press[2] & ~press[1] & ~press[0];

  state_t          state_q, state_d;
  logic [4:0]      frog_col_q, frog_col_d;
  logic [3:0]      frog_row_q, frog_row_d;
  logic [3:0]      level_q, level_d;
  logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            hit_q, hit_d;
  logic            win_q, win_d;
  logic            collide;
  logic [5:0]      car_x;
  logic [3:0]      car_y;

  // Wide-car span is compared in 6 bits so x+3 cannot wrap back onto low columns.
  always_comb begin
    collide = 1'b0;
    car_x   = '0;
    car_y   = '0;
    for (int n = 0; n < 11; n++) begin
      car_x = {1'b0, cars_x[5*n +: 5]};
      car_y = cars_y[4*n +: 4];
      if (car_y == frog_row_q) begin
        if (n < 4) begin
          if (({1'b0, frog_col_q} >= car_x) && ({1'b0, frog_col_q} <= car_x + 6'd3)) collide = 1'b1;
        end else if (car_x[4:0] == frog_col_q) begin
          collide = 1'b1;
        end
      end
    end
  end

`ifdef FROG_LIVES_EN
  logic [1:0] lives_q, lives_d;
  logic       game_over_q, game_over_d;
`endif

  always_comb begin
    state_d     = state_q;
    frog_col_d  = frog_col_q;
    frog_row_d  = frog_row_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    hit_d       = 1'b0;
    win_d       = 1'b0;
`ifdef FROG_LIVES_EN
    lives_d     = lives_q;
`endif
    case (state_q)
      S_PLAY: begin
        if (collide) begin
          hit_d       = 1'b1;
          frame_cnt_d = '0;
          state_d     = S_DEAD;
        end else if (mv_up) begin
          if (frog_row_q == 4'd1) begin
            win_d      = 1'b1;
            level_d    = (level_q == 4'hF) ? level_q : level_q + 4'd1;
            frog_col_d = START_C;
            frog_row_d = START_R;
          end else if (frog_row_q != 4'd0) begin
            frog_row_d = frog_row_q - 4'd1;
          end
        end else if (mv_down) begin
          if (frog_row_q != ROW_MAX) frog_row_d = frog_row_q + 4'd1;
        end else if (mv_left) begin
          if (frog_col_q != 5'd0) frog_col_d = frog_col_q - 5'd1;
        end else if (mv_right) begin
          if (frog_col_q != COL_MAX) frog_col_d = frog_col_q + 5'd1;
        end
      end
      S_DEAD: begin
        // A tick landing while hit is still asserted belongs to the hit itself.
        if (frame_tick && !hit_q) begin
          if (frame_cnt_q == FR_MAX) begin
            frame_cnt_d = '0;
`ifdef FROG_LIVES_EN
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = S_OVER;
            end else begin
              state_d    = S_PLAY;
              frog_col_d = START_C;
              frog_row_d = START_R;
            end
`else
            state_d    = S_PLAY;
            frog_col_d = START_C;
            frog_row_d = START_R;
`endif
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      S_OVER: begin
        if (|press) begin
          state_d     = S_PLAY;
          frog_col_d  = START_C;
          frog_row_d  = START_R;
          level_d     = 4'd0;
          frame_cnt_d = '0;
`ifdef FROG_LIVES_EN
          lives_d     = 2'd3;
`endif
        end
      end
      default: state_d = S_PLAY;
    endcase
`ifdef FROG_LIVES_EN
    game_over_d = (state_d == S_OVER);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PLAY;
      frog_col_q  <= START_C;
      frog_row_q  <= START_R;
      level_q     <= 4'd0;
      frame_cnt_q <= '0;
      hit_q       <= 1'b0;
      win_q       <= 1'b0;
`ifdef FROG_LIVES_EN
      lives_q     <= 2'd3;
      game_over_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      frog_col_q  <= frog_col_d;
      frog_row_q  <= frog_row_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      hit_q       <= hit_d;
      win_q       <= win_d;
`ifdef FROG_LIVES_EN
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
`endif
    end
  end

  assign frog_col = frog_col_q;
  assign frog_row = frog_row_q;
  assign level    = level_q;
  assign hit      = hit_q;
  assign win      = win_q;
`ifdef FROG_LIVES_EN
  assign lives     = lives_q;
  assign game_over = game_over_q;
`else
  assign lives     = 2'd3;
  assign game_over = 1'b0;
`endif

endmodule

// File: tb/tb_frog_controller.sv
// Self-checking bench for frog_controller: randomized presses and car placements
// checked against a grid-level game model. Honours FROG_LIVES_EN if defined.

module tb_frog_controller;

  localparam int DB = 16;
  localparam int DF = 4;
  localparam int GC = 20;
  localparam int GR = 15;
  localparam int SC = 10;
  localparam int SR = 14;
`ifdef FROG_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic        frame_tick = 1'b0;
  logic [54:0] cars_x = {11{5'd31}};
  logic [43:0] cars_y = '0;
  logic [4:0]  frog_col;
  logic [3:0]  frog_row;
  logic [3:0]  level;
  logic [1:0]  lives;
  logic        game_over, hit, win;

  frog_controller #(
    .DEBOUNCE_CYCLES(DB), .GRID_COLS(GC), .GRID_ROWS(GR),
    .START_COL(SC), .START_ROW(SR), .DEATH_FRAMES(DF)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .frame_tick(frame_tick), .cars_x(cars_x), .cars_y(cars_y),
    .frog_col(frog_col), .frog_row(frog_row), .level(level), .lives(lives),
    .game_over(game_over), .hit(hit), .win(win)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int win_cnt = 0;
  int hit_cnt = 0;

  always @(negedge clk) begin
    if (win === 1'b1) win_cnt++;
    if (hit === 1'b1) hit_cnt++;
  end

  // Game model in grid terms
  int m_col, m_row, m_level, m_lives, m_wins = 0, m_hits = 0;
  bit m_over;

  task automatic model_reset();
    m_col = SC; m_row = SR; m_level = 0; m_lives = 3; m_over = 1'b0;
  endtask

  task automatic model_press(input logic [3:0] mask);
    if (mask == 4'd0) return;
    if (m_over) begin
      model_reset();
    end else if (mask[0]) begin
      if (m_row > 0) m_row--;
      if (m_row == 0) begin
        m_wins++;
        m_level = (m_level < 15) ? m_level + 1 : 15;
        m_col = SC; m_row = SR;
      end
    end else if (mask[1]) begin
      if (m_row < GR - 1) m_row++;
    end else if (mask[2]) begin
      if (m_col > 0) m_col--;
    end else if (mask[3]) begin
      if (m_col < GC - 1) m_col++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic park_cars();
    cars_x = {11{5'd31}};
    cars_y = '0;
  endtask

  task automatic press(input logic [3:0] mask);
    {btn_right, btn_left, btn_down, btn_up} = mask;
    cycles(DB + 6);
    {btn_right, btn_left, btn_down, btn_up} = 4'b0000;
    cycles(DB + 6);
    model_press(mask);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(2);
    checks++;
    if ({frog_col, frog_row, level, lives, game_over, hit, win} !== {5'(SC), 4'(SR), 4'd0, 2'd3, 3'b000})
      begin errors++; $display("[TB] FAIL reset_held: got col=%0d row=%0d lvl=%0d lives=%0d go=%b hit=%b win=%b required 10 14 0 3 0 0 0", frog_col, frog_row, level, lives, game_over, hit, win); end
    rst = 1'b0;
    cycles(1);
    model_reset();
    checks++;
    if ({frog_col, frog_row, level, lives, game_over, hit, win} !== {5'(SC), 4'(SR), 4'd0, 2'd3, 3'b000})
      begin errors++; $display("[TB] FAIL reset_release: got col=%0d row=%0d lvl=%0d lives=%0d required 10 14 0 3", frog_col, frog_row, level, lives); end
  endtask

  task automatic test_up_once();
    int n;
    n = 0;
    btn_up = 1'b1;
    while (n < 3 * DB) begin
      cycles(1);
      n++;
      if (frog_row != 4'(SR)) break;
    end
    checks++;
    if (n != DB + 3) begin errors++; $display("[TB] FAIL press_latency: got %0d cycles required %0d", n, DB + 3); end
    cycles(DB + 10 - n);
    checks++;
    if ({frog_col, frog_row} !== {5'(SC), 4'(SR - 1)})
      begin errors++; $display("[TB] FAIL up_held_once: got (%0d,%0d) required (%0d,%0d)", frog_col, frog_row, SC, SR - 1); end
    btn_up = 1'b0;
    cycles(DB + 6);
    model_press(4'b0001);
    checks++;
    if ({frog_col, frog_row} !== {5'(m_col), 4'(m_row)})
      begin errors++; $display("[TB] FAIL up_release: got (%0d,%0d) required (%0d,%0d)", frog_col, frog_row, m_col, m_row); end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      btn_left = ~btn_left;
      cycles(5);
    end
    cycles(DB + 6);
    checks++;
    if ({frog_col, frog_row} !== {5'(m_col), 4'(m_row)})
      begin errors++; $display("[TB] FAIL bounce_no_move: got (%0d,%0d) required (%0d,%0d)", frog_col, frog_row, m_col, m_row); end
    press(4'b0100);
    checks++;
    if ({frog_col, frog_row} !== {5'(m_col), 4'(m_row)} || m_col != SC - 1)
      begin errors++; $display("[TB] FAIL bounce_then_hold: got (%0d,%0d) required (%0d,%0d)", frog_col, frog_row, m_col, m_row); end
  endtask

  task automatic test_win();
    for (int i = 0; i < SR; i++) begin
      press(4'b0001);
      checks++;
      if ({frog_col, frog_row, level} !== {5'(m_col), 4'(m_row), 4'(m_level)} || win_cnt != m_wins)
        begin errors++; $display("[TB] FAIL win_walk_%0d: got (%0d,%0d) lvl=%0d wins=%0d required (%0d,%0d) lvl=%0d wins=%0d", i, frog_col, frog_row, level, win_cnt, m_col, m_row, m_level, m_wins); end
    end
    checks++;
    if (level !== 4'd1 || win_cnt != 1)
      begin errors++; $display("[TB] FAIL win_final: got lvl=%0d wins=%0d required 1 1", level, win_cnt); end
  endtask

  task automatic test_clamp();
    int w0, h0;
    w0 = win_cnt; h0 = hit_cnt;
    press(4'b0010);
    checks++;
    if ({frog_col, frog_row} !== {5'(SC), 4'(SR)})
      begin errors++; $display("[TB] FAIL clamp_down: got (%0d,%0d) required (%0d,%0d)", frog_col, frog_row, SC, SR); end
    while (m_col < GC - 1) press(4'b1000);
    press(4'b1000);
    checks++;
    if ({frog_col, frog_row} !== {5'(GC - 1), 4'(SR)} || win_cnt != w0 || hit_cnt != h0)
      begin errors++; $display("[TB] FAIL clamp_right: got (%0d,%0d) win=%0d hit=%0d required (%0d,%0d) %0d %0d", frog_col, frog_row, win_cnt, hit_cnt, GC - 1, SR, w0, h0); end
  endtask

  task automatic test_random_moves();
    logic [3:0] mask;
    for (int i = 0; i < 30; i++) begin
      mask = 4'($urandom_range(15, 1));
      press(mask);
      checks++;
      if ({frog_col, frog_row, level} !== {5'(m_col), 4'(m_row), 4'(m_level)} || win_cnt != m_wins)
        begin errors++; $display("[TB] FAIL random_move_%0d mask=%b: got (%0d,%0d) lvl=%0d wins=%0d required (%0d,%0d) lvl=%0d wins=%0d", i, mask, frog_col, frog_row, level, win_cnt, m_col, m_row, m_level, m_wins); end
    end
  endtask

  task automatic test_near_miss();
    int h0;
    h0 = hit_cnt;
    cars_x[0 +: 5] = 5'(m_col + 1); cars_y[0 +: 4] = 4'(m_row);
    if (m_col >= 4) begin cars_x[5 +: 5] = 5'(m_col - 4); cars_y[4 +: 4] = 4'(m_row); end
    cars_x[25 +: 5] = 5'(m_col + 1); cars_y[20 +: 4] = 4'(m_row);
    cars_x[40 +: 5] = 5'(m_col);     cars_y[32 +: 4] = 4'(m_row + 1);
    cycles(4);
    checks++;
    if (hit_cnt != h0 || {frog_col, frog_row} !== {5'(m_col), 4'(m_row)})
      begin errors++; $display("[TB] FAIL near_miss: got hits=%0d pos=(%0d,%0d) required %0d (%0d,%0d)", hit_cnt, frog_col, frog_row, h0, m_col, m_row); end
    park_cars();
    cycles(1);
  endtask

  task automatic kill(input bit one_wide);
    int n, x, dcol, drow;
    n    = one_wide ? int'($urandom_range(10, 4)) : int'($urandom_range(3, 0));
    x    = one_wide ? m_col : m_col - int'($urandom_range((m_col < 3) ? m_col : 3, 0));
    dcol = m_col; drow = m_row;
    cars_x[5*n +: 5] = 5'(x);
    cars_y[4*n +: 4] = 4'(m_row);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (hit !== 1'b1) begin errors++; $display("[TB] FAIL hit_latency car%0d x=%0d: got hit=%b required 1", n + 1, x, hit); end
    park_cars();
    @(posedge clk); #1;
    frame_tick = 1'b0;
    checks++;
    if (hit !== 1'b0) begin errors++; $display("[TB] FAIL hit_pulse_len: got hit=%b required 0", hit); end
    m_hits++;
    for (int t = 0; t < DF; t++) begin
      cycles(2);
      frame_tick = 1'b1;
      cycles(1);
      frame_tick = 1'b0;
      if (t == DF - 2) begin
        checks++;
        if ({frog_col, frog_row} !== {5'(dcol), 4'(drow)} || lives !== 2'(m_lives))
          begin errors++; $display("[TB] FAIL dead_frozen: got (%0d,%0d) lives=%0d required (%0d,%0d) lives=%0d", frog_col, frog_row, lives, dcol, drow, m_lives); end
      end
    end
    if (LIVES_EN) m_lives--;
    if (m_lives == 0) m_over = 1'b1;
    else begin m_col = SC; m_row = SR; end
    checks++;
    if ({frog_col, frog_row, lives, game_over} !== {5'(m_col), 4'(m_row), 2'(m_lives), m_over} || hit_cnt != m_hits)
      begin errors++; $display("[TB] FAIL death_end: got (%0d,%0d) lives=%0d go=%b hits=%0d required (%0d,%0d) lives=%0d go=%b hits=%0d", frog_col, frog_row, lives, game_over, hit_cnt, m_col, m_row, m_lives, m_over, m_hits); end
  endtask

  task automatic test_deaths();
    press(4'b0001);
    press(4'b0100);
    kill(1'b0);
    press(4'b0001);
    kill(1'b1);
  endtask

  task automatic test_game_over();
    int h0;
    int deaths;
    deaths = 0;
    while (!m_over && deaths < 3) begin
      press(4'b0001);
      kill(deaths[0]);
      deaths++;
    end
    checks++;
    if (lives !== 2'(m_lives) || game_over !== m_over || (LIVES_EN ? m_lives != 0 : m_lives != 3))
      begin errors++; $display("[TB] FAIL game_over_state: got lives=%0d go=%b required lives=%0d go=%b", lives, game_over, m_lives, m_over); end
    if (m_over) begin
      h0 = hit_cnt;
      cars_x[0 +: 5] = 5'(m_col); cars_y[0 +: 4] = 4'(m_row);
      cycles(4);
      checks++;
      if (hit_cnt != h0 || game_over !== 1'b1)
        begin errors++; $display("[TB] FAIL over_frozen: got hits=%0d go=%b required %0d 1", hit_cnt, game_over, h0); end
      park_cars();
      press(4'b1000);
      checks++;
      if ({frog_col, frog_row, level, lives, game_over} !== {5'(SC), 4'(SR), 4'd0, 2'd3, 1'b0})
        begin errors++; $display("[TB] FAIL over_restart: got (%0d,%0d) lvl=%0d lives=%0d go=%b required (10,14) 0 3 0", frog_col, frog_row, level, lives, game_over); end
    end
  endtask

  task automatic test_reset_mid_dead();
    press(4'b0001);
    cars_x[0 +: 5] = 5'(m_col); cars_y[0 +: 4] = 4'(m_row);
    cycles(1);
    park_cars();
    m_hits++;
    for (int t = 0; t < 2; t++) begin
      cycles(2); frame_tick = 1'b1; cycles(1); frame_tick = 1'b0;
    end
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({frog_col, frog_row, level, lives, game_over, hit} !== {5'(SC), 4'(SR), 4'd0, 2'd3, 2'b00})
      begin errors++; $display("[TB] FAIL reset_mid_dead: got (%0d,%0d) lvl=%0d lives=%0d required (10,14) 0 3", frog_col, frog_row, level, lives); end
    for (int t = 0; t < DF + 1; t++) begin
      cycles(2); frame_tick = 1'b1; cycles(1); frame_tick = 1'b0;
    end
    press(4'b0001);
    checks++;
    if ({frog_row, lives, game_over} !== {4'(m_row), 2'd3, 1'b0} || hit_cnt != m_hits)
      begin errors++; $display("[TB] FAIL after_reset_play: got row=%0d lives=%0d hits=%0d required row=%0d lives=3 hits=%0d", frog_row, lives, hit_cnt, m_row, m_hits); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_once();
    test_bounce();
    test_reset();
    test_win();
    test_clamp();
    test_random_moves();
    test_near_miss();
    test_deaths();
    test_game_over();
    test_reset_mid_dead();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
